sha256_block_padder: RTL and testbench

SHA256_BLOCK_PADDER -- requirements
Module: sha256_block_padder

---
 rtl/sha256_pkg.sv | 37 +++
 rtl/sha256_block_padder.sv | 184 ++++++++++++++++++
 tb/tb_sha256_block_padder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared types, constants and helpers for the SHA-256 message
//                block padder (word/block types, FSM states, pad word, block
//                count and byte-reversal helpers).
//  Revision    : 1.0  initial release
// ============================================================================
package sha256_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [511:0] block_t;

    // Padder control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        OFFER = 2'd2,
        DONE  = 2'd3
    } state_t;

    // First pad word: a single '1' bit directly after the message
    localparam word_t PAD_WORD = 32'h8000_0000;

    // Number of 512-bit blocks needed for a message of the given word count,
    // leaving room for the pad word and the 64-bit length field.
    function automatic int num_blocks(input int words);
        return (words + 2) / 16 + 1;
    endfunction

    // Reverse the byte order of one word
    function automatic word_t byte_swap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_block_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_block_padder
//  Description : Reads a NUM_OF_WORDS-word message from memory and emits it
//                as SHA-256 padded 512-bit blocks over a valid/ready handshake.
//                Each block is filled in a fixed 17-cycle window (16 word
//                slots plus one capture cycle), then held until accepted.
//                Optional build macro SHA_PAD_BSWAP_EN byte-reverses every
//                memory word before it enters the block (pad and length words
//                are never swapped).
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_block_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic [511:0] block_data,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_last,
    output logic         busy,
    output logic         done
);

    localparam int          c_num_blocks = num_blocks(NUM_OF_WORDS);
    localparam logic [4:0]  c_last_blk   = 5'(c_num_blocks - 1);
    localparam logic [15:0] c_n          = 16'(NUM_OF_WORDS);
    localparam word_t       c_len        = 32'(NUM_OF_WORDS * 32);

    state_t      r_state;
    state_t      w_state_next;

    logic [4:0]  r_blk;          // current block index
    logic [4:0]  r_slot;         // FILL slot counter, 0..16
    logic [15:0] r_base;         // captured message_addr
    logic [15:0] r_mem_addr;     // registered read address
    word_t       r_buf [16];     // block word buffer

    logic [15:0] w_blk_g;        // global index of word 0 of the current block
    logic [15:0] w_next_g;       // global index addressed in the next slot
    logic [4:0]  w_blk_inc;
    logic [15:0] w_xfer_g;       // global index of word 0 of the next block
    logic [3:0]  w_cap_idx;      // buffer word captured this cycle
    logic [15:0] w_cap_g;        // global index of the captured word
    logic        w_last_blk;
    word_t       w_mem_word;
    word_t       w_cap_word;

    assign w_blk_g    = {7'd0, r_blk, 4'd0};
    assign w_next_g   = w_blk_g + {11'd0, r_slot} + 16'd1;
    assign w_blk_inc  = r_blk + 5'd1;
    assign w_xfer_g   = {7'd0, w_blk_inc, 4'd0};
    assign w_cap_idx  = 4'(r_slot - 5'd1);
    assign w_cap_g    = w_blk_g + {12'd0, w_cap_idx};
    assign w_last_blk = (r_blk == c_last_blk);

    assign mem_addr   = r_mem_addr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs; all outputs derive from registers only
    always_comb begin
        w_state_next = r_state;
        block_valid  = 1'b0;
        block_last   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (r_slot == 5'd16) begin
                    w_state_next = OFFER;
                end
            end
            OFFER: begin
                busy        = 1'b1;
                block_valid = 1'b1;
                block_last  = w_last_blk;
                if (block_ready) begin
                    w_state_next = w_last_blk ? DONE : FILL;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Select the word to store: message data, pad word, length, or zero
    always_comb begin
`ifdef SHA_PAD_BSWAP_EN
        w_mem_word = byte_swap(mem_read_data);
`else
        w_mem_word = mem_read_data;
`endif
        w_cap_word = '0;
        if (w_cap_g < c_n) begin
            w_cap_word = w_mem_word;
        end else if (w_cap_g == c_n) begin
            w_cap_word = PAD_WORD;
        end else if (w_last_blk && (w_cap_idx == 4'd15)) begin
            w_cap_word = c_len;
        end
    end

    // Address generation, slot counting and word capture.
    // The read address for slot k+1 is registered at the end of slot k so it
    // is on mem_addr during slot k+1; its data arrives one cycle later.
    // Pad slots leave the address untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk      <= '0;
            r_slot     <= '0;
            r_base     <= '0;
            r_mem_addr <= '0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base     <= message_addr;
                        r_mem_addr <= message_addr;
                        r_blk      <= '0;
                        r_slot     <= '0;
                    end
                end
                FILL: begin
                    r_slot <= r_slot + 5'd1;
                    if (r_slot != 5'd0) begin
                        r_buf[w_cap_idx] <= w_cap_word;
                    end
                    if ((r_slot < 5'd15) && (w_next_g < c_n)) begin
                        r_mem_addr <= r_base + w_next_g;
                    end
                end
                OFFER: begin
                    if (block_ready && !w_last_blk) begin
                        r_blk  <= w_blk_inc;
                        r_slot <= '0;
                        if (w_xfer_g < c_n) begin
                            r_mem_addr <= r_base + w_xfer_g;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the word buffer onto the block bus, word k at bits [32k+31:32k]
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pack
            assign block_data[32*gi +: 32] = r_buf[gi];
        end
    endgenerate

endmodule : sha256_block_padder
`default_nettype wire

// File: tb/tb_sha256_block_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_block_padder
//  Description : Scoreboard bench for sha256_block_padder. Two instances:
//                N=20 (two blocks) and N=13 (one block). Expected blocks are
//                queued by the stimulus; negedge monitors pop and compare on
//                every transfer, and also check valid latency, hold stability
//                and done placement. Honours SHA_PAD_BSWAP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha256_block_padder;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    int           cyc = 0;

    logic         start_a, start_b;
    logic [15:0]  addr_a, addr_b;
    logic [15:0]  mem_addr_a, mem_addr_b;
    logic [31:0]  rdata_a, rdata_b;
    logic [511:0] data_a, data_b;
    logic         valid_a, valid_b, ready_a, ready_b;
    logic         last_a, last_b, busy_a, busy_b, done_a, done_b;

    logic [31:0]  mem [0:65535];

    int           checks   = 0;
    int           failures = 0;
    exp_t         q_a[$];
    exp_t         q_b[$];
    logic [15:0]  alog[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous message memory: data valid one cycle after the address
    always @(posedge clk) begin
        rdata_a <= mem[mem_addr_a];
        rdata_b <= mem[mem_addr_b];
    end

    sha256_block_padder #(.NUM_OF_WORDS(20)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .message_addr(addr_a),
        .mem_addr(mem_addr_a), .mem_read_data(rdata_a), .block_data(data_a),
        .block_valid(valid_a), .block_ready(ready_a), .block_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    sha256_block_padder #(.NUM_OF_WORDS(13)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .message_addr(addr_b),
        .mem_addr(mem_addr_b), .mem_read_data(rdata_b), .block_data(data_b),
        .block_valid(valid_b), .block_ready(ready_b), .block_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] x);
`ifdef SHA_PAD_BSWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    // ---------------- monitor for instance A ----------------
    logic         pv_a = 1'b0, pr_a = 1'b0, pl_a = 1'b0, pxl_a = 1'b0, pb_a = 1'b0;
    logic [511:0] pd_a = '0;
    logic [15:0]  pa_a = '0;
    int           ref_a = -1000;
    int           dones_a = 0;

    always @(negedge clk) begin
        if (reset) begin
            pv_a  <= 1'b0;
            pr_a  <= 1'b0;
            pxl_a <= 1'b0;
            pb_a  <= 1'b0;
            ref_a <= -1000;
        end else begin
            if (busy_a && !pb_a) ref_a <= cyc - 1;
            if (busy_a && (mem_addr_a != pa_a)) alog.push_back(mem_addr_a);
            if (valid_a && !pv_a) chk("valid_latency_a", 512'(cyc - ref_a), 512'd18);
            if (valid_a && pv_a && !pr_a) begin
                chk("hold_data_a", data_a, pd_a);
                chk("hold_last_a", 512'(last_a), 512'(pl_a));
            end
            if (done_a) begin
                dones_a <= dones_a + 1;
                chk("done_after_last_a", 512'(pxl_a), 512'd1);
            end
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    chk("unexpected_xfer_a", 512'd1, 512'd0);
                end else begin
                    chk("block_data_a", data_a, q_a[0].data);
                    chk("block_last_a", 512'(last_a), 512'(q_a[0].last));
                    q_a.delete(0);
                end
                ref_a <= cyc;
            end
            pxl_a <= valid_a && ready_a && last_a;
            pv_a  <= valid_a;
            pr_a  <= ready_a;
            pd_a  <= data_a;
            pl_a  <= last_a;
            pb_a  <= busy_a;
        end
        pa_a <= mem_addr_a;
    end

    // ---------------- monitor for instance B ----------------
    logic pxl_b = 1'b0;
    int   dones_b = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (done_b) begin
                dones_b <= dones_b + 1;
                chk("done_after_last_b", 512'(pxl_b), 512'd1);
            end
            if (valid_b && ready_b) begin
                if (q_b.size() == 0) begin
                    chk("unexpected_xfer_b", 512'd1, 512'd0);
                end else begin
                    chk("block_data_b", data_b, q_b[0].data);
                    chk("block_last_b", 512'(last_b), 512'(q_b[0].last));
                    q_b.delete(0);
                end
            end
            pxl_b <= valid_b && ready_b && last_b;
        end else begin
            pxl_b <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill_mem(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) mem[16'(base + 16'(i))] = 32'(i + 1);
    endtask

    // Two expected blocks for N=20 with memory word i = i+1 (word 0 = w0)
    task automatic push_n20(input logic [31:0] w0);
        exp_t e;
        e.data = '0;
        for (int k = 0; k < 16; k++) e.data[32*k +: 32] = (k == 0) ? w0 : sw(32'(k + 1));
        e.last = 1'b0;
        q_a.push_back(e);
        e.data = '0;
        for (int k = 0; k < 4; k++) e.data[32*k +: 32] = sw(32'(17 + k));
        e.data[32*4  +: 32] = 32'h8000_0000;
        e.data[32*14 +: 32] = 32'h0000_0000;
        e.data[32*15 +: 32] = 32'h0000_0280;
        e.last = 1'b1;
        q_a.push_back(e);
    endtask

    task automatic go_a(input logic [15:0] base);
        @(posedge clk); #1 start_a = 1'b1; addr_a = base;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 300) begin @(negedge clk); n++; end
        chk("done_timeout_a", 512'(done_a), 512'd1);
    endtask

    task automatic wait_valid_a();
        int n = 0;
        while (!valid_a && n < 100) begin @(negedge clk); n++; end
        chk("valid_timeout_a", 512'(valid_a), 512'd1);
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_valid"},    512'(valid_a),    512'd0);
        chk({tag, "_last"},     512'(last_a),     512'd0);
        chk({tag, "_busy"},     512'(busy_a),     512'd0);
        chk({tag, "_done"},     512'(done_a),     512'd0);
        chk({tag, "_mem_addr"}, 512'(mem_addr_a), 512'd0);
        chk({tag, "_data"},     data_a,           512'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        exp_t        eb;
        logic [15:0] exp_addr [4];
        int          n;

        reset   = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        addr_a  = '0;   addr_b  = '0;
        ready_a = 1'b1; ready_b = 1'b1;
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF;
        exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_a("reset");
        chk("reset_b_valid", 512'(valid_b), 512'd0);
        chk("reset_b_busy",  512'(busy_b),  512'd0);

        // Two-block run; start in the first cycle after reset release
        fill_mem(16'h0000, 20);
        push_n20(sw(32'h1));
        @(posedge clk); #1 reset = 1'b0; start_a = 1'b1; addr_a = 16'h0000;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done_a();

        // Back-pressure for 10 cycles; a start during FILL is ignored
        ready_a = 1'b0;
        push_n20(sw(32'h1));
        go_a(16'h0000);
        repeat (3) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_valid_a();
        repeat (10) @(posedge clk);
        #1 ready_a = 1'b1;
        wait_done_a();

        // Reset during FILL of block 1, then a clean rerun
        push_n20(sw(32'h1));
        go_a(16'h0000);
        wait_valid_a();
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        q_a.delete();
        @(negedge clk);
        check_reset_a("fill_abort");
        push_n20(sw(32'h1));
        go_a(16'h0000);
        wait_done_a();

        // Reset while a block is pending in OFFER
        ready_a = 1'b0;
        push_n20(sw(32'h1));
        go_a(16'h0000);
        wait_valid_a();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        q_a.delete();
        @(negedge clk);
        check_reset_a("offer_abort");
        ready_a = 1'b1;

        // Address wrap from 0xFFFE, plus a byte-order probe word
        fill_mem(16'hFFFE, 20);
        mem[16'hFFFE] = 32'h1122_3344;
        alog.delete();
        push_n20(sw(32'h1122_3344));
        go_a(16'hFFFE);
        wait_done_a();
        chk("addr_change_count", 512'(alog.size()), 512'd20);
        for (int i = 0; i < 4 && i < alog.size(); i++)
            chk("addr_sequence", 512'(alog[i]), 512'(exp_addr[i]));

        // Single-block run, N=13
        fill_mem(16'h0200, 13);
        eb.data = '0;
        for (int k = 0; k < 13; k++) eb.data[32*k +: 32] = sw(32'(k + 1));
        eb.data[32*13 +: 32] = 32'h8000_0000;
        eb.data[32*15 +: 32] = 32'h0000_01A0;
        eb.last = 1'b1;
        q_b.push_back(eb);
        @(posedge clk); #1 start_b = 1'b1; addr_b = 16'h0200;
        @(posedge clk); #1 start_b = 1'b0;
        n = 0;
        while (!done_b && n < 100) begin @(negedge clk); n++; end
        chk("done_timeout_b", 512'(done_b), 512'd1);
        repeat (2) @(negedge clk);

        chk("done_count_a", 512'(dones_a), 512'd4);
        chk("done_count_b", 512'(dones_b), 512'd1);
        chk("queue_empty_a", 512'(q_a.size()), 512'd0);
        chk("queue_empty_b", 512'(q_b.size()), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sha256_block_padder
`default_nettype wire
